// File: rtl/common_lib.sv
// Shared helpers used across the codebase.
// clog2: ceiling log2 of a value, usable in parameter defaults.
package common_lib;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/elastic_pipe_chain_pkg.sv
// Types shared between the elastic pipe chain and its stage registers.
// stage_op_e: per-stage command decoded by the chain each cycle.
package elastic_pipe_chain_pkg;

  typedef enum logic [1:0] {
    StageHold  = 2'd0,
    StageLoad  = 2'd1,
    StageFlush = 2'd2
  } stage_op_e;

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register slot of the elastic chain: a data register and its valid bit.
// Ports:
//   sys_clk, rstn      - clock, synchronous active-low reset
//   op_i               - hold / load from upstream / flush (drop valid)
//   up_valid_i/data_i  - upstream slot contents
//   valid_o, data_o    - registered slot contents
module elastic_pipe_stage
  import elastic_pipe_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  stage_op_e        op_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    unique case (op_i)
      StageLoad: begin
        valid_d = up_valid_i;
        // Data only moves with a valid token so idle slots keep their contents.
        if (up_valid_i) begin
          data_d = up_data_i;
        end
      end
      // Flush drops the token but leaves the data register alone.
      StageFlush: valid_d = 1'b0;
      default:    ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/elastic_pipe_chain.sv
// Elastic pipeline of DEPTH valid/ready register stages with bubble collapsing,
// flush and a registered occupancy count.
// Ports:
//   sys_clk, rstn                   - clock, synchronous active-low reset
//   in_valid_i/in_data_i/in_ready_o - upstream handshake
//   out_valid_o/out_data_o/out_ready_i - downstream handshake (last stage)
//   flush_i                         - drop every in-flight token next edge
//   stage_probe_o, stage_valid_o    - per-stage data / valid, stage k at slot k
//   occupancy_o                     - number of valid stages
module elastic_pipe_chain
  import common_lib::*;
  import elastic_pipe_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   in_valid_i,
  input  logic [WIDTH-1:0]       in_data_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  output logic [WIDTH-1:0]       out_data_o,
  input  logic                   out_ready_i,
  input  logic                   flush_i,
  output logic [DEPTH*WIDTH-1:0] stage_probe_o,
  output logic [DEPTH-1:0]       stage_valid_o,
  output logic [CNT_W-1:0]       occupancy_o
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            rdy;
  stage_op_e                   op [DEPTH];
  logic [CNT_W-1:0]            occ_d, occ_q;
  logic                        in_xfer, out_xfer;

  // A stage can take new data if it is empty or its successor can take its
  // data; this depends only on valid bits and out_ready_i, never on in_valid_i.
  always_comb begin
    logic r;
    r = out_ready_i;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      r      = ~v[k] | r;
      rdy[k] = r;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid_i;
      assign up_data  = in_data_i;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    assign op[k] = flush_i ? StageFlush : (rdy[k] ? StageLoad : StageHold);

    elastic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .sys_clk   (sys_clk),
      .rstn      (rstn),
      .op_i      (op[k]),
      .up_valid_i(up_valid),
      .up_data_i (up_data),
      .valid_o   (v[k]),
      .data_o    (d[k])
    );
  end

  assign in_ready_o    = rdy[0] & ~flush_i;
  assign out_valid_o   = v[DEPTH-1];
  assign out_data_o    = d[DEPTH-1];
  assign stage_probe_o = d;
  assign stage_valid_o = v;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: doc/elastic_pipe_chain.md
ELASTIC_PIPE_CHAIN -- requirements
Module: elastic_pipe_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bitwidth, >=1.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages, >=1.
REQ-003 SHALL have parameter CNT_W, default clog2(DEPTH+1): occupancy counter width.
REQ-004 SHALL have port sys_clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid_i, input, 1: upstream data valid.
REQ-007 SHALL have port in_data_i, input, WIDTH: upstream data.
REQ-008 SHALL have port in_ready_o, output, 1: chain accepts data this cycle.
REQ-009 SHALL have port out_valid_o, output, 1: last stage holds valid data.
REQ-010 SHALL have port out_data_o, output, WIDTH: last stage data.
REQ-011 SHALL have port out_ready_i, input, 1: downstream accepts data.
REQ-012 SHALL have port flush_i, input, 1: discard all in-flight data.
REQ-013 SHALL have port stage_probe_o, output, DEPTH*WIDTH: data of stage k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-014 SHALL have port stage_valid_o, output, DEPTH: valid bit of stage k at bit k.
REQ-015 SHALL have port occupancy_o, output, CNT_W: count of valid stages.

Function
REQ-016 SHALL hold per stage k a data register d[k] and a valid bit v[k]; stage 0 is fed from in_data_i, stage k>0 from stage k-1.
REQ-017 SHALL compute stage readiness combinationally: rdy[DEPTH]=out_ready_i; rdy[k]=~v[k] | rdy[k+1].
REQ-018 SHALL drive in_ready_o = rdy[0] & ~flush_i.
REQ-019 SHALL load stage k when rdy[k]=1: d[k] <= upstream data and v[k] <= upstream valid. Data SHALL load only when upstream valid=1; it SHALL be held otherwise.
REQ-020 SHALL hold d[k] and v[k] unchanged when rdy[k]=0 (stall).
REQ-021 SHALL collapse bubbles: an empty stage accepts from upstream even when downstream is stalled.
REQ-022 SHALL define a transfer as valid&ready at either end. No data SHALL be lost or duplicated.
REQ-023 SHALL have latency exactly DEPTH cycles from input transfer to out_valid_o when out_ready_i is held at 1.
REQ-024 SHALL sustain a throughput of one transfer per cycle when out_ready_i=1 and in_valid_i=1.
REQ-025 SHALL drive out_valid_o=v[DEPTH-1] and out_data_o=d[DEPTH-1].
REQ-026 On flush_i=1, SHALL clear all v[k] to 0 at the next edge; d[k] SHALL be unchanged and no input SHALL be accepted. Flush SHALL take priority over any simultaneous load.
REQ-027 SHALL maintain occupancy_o as a registered count equal to popcount(v):
- +1 on input transfer without output transfer
- -1 on output transfer without input transfer
- unchanged when both or neither occur
- set to 0 on flush
REQ-028 SHALL keep occupancy_o within 0..DEPTH; in_ready_o=0 SHALL occur only when occupancy_o=DEPTH and out_ready_i=0, or when flush_i=1.
REQ-029 SHALL ignore in_data_i when in_valid_i=0.

Reset
REQ-030 When rstn=0 at a clock edge, SHALL clear all d[k], v[k] and occupancy_o to 0; out_valid_o=0, out_data_o=0, stage_probe_o=0, stage_valid_o=0.
REQ-031 SHALL take reset mid-operation over flush and load; in-flight data SHALL be discarded.
REQ-032 During reset, SHALL drive in_ready_o combinationally as specified (1 when out_ready_i=1 or the chain is empty); upstream SHALL be gated by rstn externally.

Structure
REQ-033 SHALL take the clog2 helper function from the shared common_lib package.
REQ-034 SHALL implement one sub-module, elastic_pipe_stage (one d/v register pair with load/hold/flush), instantiated DEPTH times in a generate loop.
REQ-035 SHALL contain no latches and no combinational path from in_valid_i to in_ready_o.

Verification (WIDTH=8, DEPTH=4)
REQ-036 Streaming: in_valid_i=1 with data 0x01..0x08 on consecutive cycles, out_ready_i=1 -> out_data_o 0x01..0x08 on cycles 4..11, out_valid_o continuous, occupancy_o=4 steady.
REQ-037 Backpressure: out_ready_i=0 while streaming 0x10..0x15 -> in_ready_o falls after 4 accepts (0x10..0x13), occupancy_o=4; release -> 0x10..0x15 emerge in order, none lost.
REQ-038 Bubble collapse: send 0xA0, idle 2 cycles, send 0xA1 with out_ready_i=0 -> stage_valid_o=4'b1100, then 4'b1110 after 0xA2, in_ready_o remains 1.
REQ-039 Flush: occupancy_o=3, assert flush_i with in_valid_i=1 -> next cycle stage_valid_o=0, occupancy_o=0, the input is not accepted, out_valid_o=0.
REQ-040 Reset mid-stream: rstn=0 for 1 cycle while full -> all outputs 0 next cycle; the subsequent input 0x55 appears at the output after 4 cycles.
REQ-041 Random: random in_valid_i and out_ready_i (50%) over 10,000 cycles, scoreboard -> order preserved, occupancy_o==popcount(stage_valid_o) every cycle.
